mmio_done_monitor: RTL

Synthesizable, parametrised completion monitor that snoops the CPU native memory bus of riscv_top.
- Detects the DONE-flag store, captures exit code and cycle count, and flags pass or fail.
- Provides a watchdog timeout and NUM_CH checkpoint channels that timestamp the first store to each checkpoint address.
- Sits beside the core and is usable both in simulation benches and on FPGA builds; it is a pure observer and never drives the bus.

---
 rtl/mon_pkg.sv | 31 +++
 rtl/mon_sat_counter.sv | 20 ++
 rtl/mmio_done_monitor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mon_pkg.sv
// Shared types and default constants for the MMIO completion monitor.
package mon_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DONE    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    DONE    = ST_DONE,
    TIMEOUT = ST_TIMEOUT
  } mon_state_t;

  localparam logic [31:0] MON_DONE_ADDR  = 32'h0000_0010;
  localparam logic [31:0] MON_CKPT_BASE  = 32'h0000_0100;
  localparam logic [31:0] MON_PASS_VALUE = 32'd1;
  localparam int unsigned MON_MAX_CH     = 16;

  // True when addr coincides with one of the num_ch checkpoint word addresses.
  function automatic logic addr_overlaps_ckpt(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input int unsigned num_ch);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < num_ch; i++) begin
      if (addr == base + 64'(4 * i)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// Up-counter that saturates at all-ones and holds while frozen.
module mon_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !freeze && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mmio_done_monitor.sv
// Passive bus snooper: DONE-flag capture, watchdog and checkpoint timestamps.
// Optional stall counter output enabled by defining MON_STALL_CNT_EN.
module mmio_done_monitor
  import mon_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter int unsigned        CNT_W          = 32,
  parameter logic [ADDR_W-1:0]  DONE_ADDR      = ADDR_W'(MON_DONE_ADDR),
  parameter logic [DATA_W-1:0]  PASS_VALUE     = DATA_W'(MON_PASS_VALUE),
  parameter int unsigned        TIMEOUT_CYCLES = 2000000,
  parameter int unsigned        NUM_CH         = 4,
  parameter logic [ADDR_W-1:0]  CKPT_BASE      = ADDR_W'(MON_CKPT_BASE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  input  logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W/8-1:0]     mem_wstrb,
  input  logic [DATA_W-1:0]       mem_wdata,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [DATA_W-1:0]       exit_code,
  output logic [CNT_W-1:0]        final_cycles,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_CH-1:0]       ch_hit,
  output logic [NUM_CH*CNT_W-1:0] ch_stamp
`ifdef MON_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]        stall_count
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_FINAL = CNT_W'(TIMEOUT_CYCLES);

  // Configuration sanity checks at elaboration.
  if (NUM_CH < 1 || NUM_CH > MON_MAX_CH) begin : g_bad_num_ch
    $error("mmio_done_monitor: NUM_CH must be in 1..16");
  end
  if (addr_overlaps_ckpt(64'(DONE_ADDR), 64'(CKPT_BASE), NUM_CH)) begin : g_bad_overlap
    $error("mmio_done_monitor: DONE_ADDR overlaps a checkpoint address");
  end

  mon_state_t          state;
  mon_state_t          state_next;
  logic                wr_c;
  logic                run_c;
  logic                done_ev_c;
  logic                timeout_ev_c;
  logic [DATA_W-1:0]   wdata_masked_c;
  logic [NUM_CH-1:0]   ch_sel_c;

  assign wr_c  = mem_valid && mem_ready && (|mem_wstrb);
  assign run_c = (state == RUN);

  // Zero the byte lanes that were not strobed.
  always_comb begin
    wdata_masked_c = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      wdata_masked_c[b*8 +: 8] = mem_wstrb[b] ? mem_wdata[b*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    ch_sel_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_sel_c[i] = wr_c && (mem_addr == CKPT_BASE + ADDR_W'(4 * i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // A DONE store in the final watchdog cycle takes priority over the timeout.
  always_comb begin
    state_next   = state;
    done_ev_c    = 1'b0;
    timeout_ev_c = 1'b0;
    case (state)
      RUN: begin
        if (wr_c && (mem_addr == DONE_ADDR)) begin
          done_ev_c  = 1'b1;
          state_next = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST)) begin
          timeout_ev_c = 1'b1;
          state_next   = TIMEOUT;
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      exit_code    <= '0;
      final_cycles <= '0;
    end else if (done_ev_c) begin
      done         <= 1'b1;
      exit_code    <= wdata_masked_c;
      final_cycles <= cycle_count;
      pass         <= (wdata_masked_c == PASS_VALUE);
    end else if (timeout_ev_c) begin
      timeout      <= 1'b1;
      final_cycles <= TO_FINAL;
      pass         <= 1'b0;
    end
  end

  // Only the first store to each checkpoint records a timestamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_hit   <= '0;
      ch_stamp <= '0;
    end else if (run_c) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_sel_c[i] && !ch_hit[i]) begin
          ch_hit[i]                <= 1'b1;
          ch_stamp[i*CNT_W +: CNT_W] <= cycle_count;
        end
      end
    end
  end

  mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (1'b1),
    .freeze (!run_c),
    .count  (cycle_count)
  );

`ifdef MON_STALL_CNT_EN
  mon_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (mem_valid && !mem_ready),
    .freeze (!run_c),
    .count  (stall_count)
  );
`endif

endmodule
